ahb_switch_master_port_derr: RTL and testbench

Master-side port of the AHB3-Lite multi-layer switch, generalized to a parametric number of slaves and PRIORITY_BITS-wide priorities. It has a built-in default slave that issues the two-cycle AHB ERROR response to unmapped accesses. Burst tracking covers all HBURST encodings. It sits between one AHB master and the per-slave arbitration ports: it decodes the address, requests a slave port, and holds the address phase while arbitration is pending.

---
 rtl/ahb_switch_master_port_derr.sv | 236 +++++++++++++++++++++++
 tb/tb_ahb_switch_master_port_derr.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_switch_master_port_derr.sv
// Master-side port of an AHB3-Lite multi-layer switch: decodes the address, requests a slave port,
// holds the address phase while arbitration is pending and answers unmapped accesses with ERROR.
module ahb_switch_master_port_derr #(
  parameter int HADDR_SIZE    = 32,
  parameter int HDATA_SIZE    = 32,
  parameter int SLAVES        = 8,
  parameter int PRIORITY_BITS = 3
) (
  input  logic                     HCLK,
  input  logic                     HRESET,
  input  logic [PRIORITY_BITS-1:0] mst_priority,
  input  logic                     mst_HSEL,
  input  logic [HADDR_SIZE-1:0]    mst_HADDR,
  input  logic [HDATA_SIZE-1:0]    mst_HWDATA,
  input  logic                     mst_HWRITE,
  input  logic [2:0]               mst_HSIZE,
  input  logic [2:0]               mst_HBURST,
  input  logic [3:0]               mst_HPROT,
  input  logic [1:0]               mst_HTRANS,
  input  logic                     mst_HMASTLOCK,
  input  logic                     mst_HREADY,
  output logic [HDATA_SIZE-1:0]    mst_HRDATA,
  output logic                     mst_HREADYOUT,
  output logic                     mst_HRESP,
  input  logic [HADDR_SIZE-1:0]    slvHADDRmask [SLAVES],
  input  logic [HADDR_SIZE-1:0]    slvHADDRbase [SLAVES],
  output logic [SLAVES-1:0]        slvHSEL,
  output logic [HADDR_SIZE-1:0]    slvHADDR,
  output logic [HDATA_SIZE-1:0]    slvHWDATA,
  output logic                     slvHWRITE,
  output logic [2:0]               slvHSIZE,
  output logic [2:0]               slvHBURST,
  output logic [3:0]               slvHPROT,
  output logic [1:0]               slvHTRANS,
  output logic                     slvHMASTLOCK,
  output logic [1:0]               slvHTRANS4sw,
  output logic                     slvHMASTLOCK4sw,
  input  logic [HDATA_SIZE-1:0]    slvHRDATA [SLAVES],
  input  logic [SLAVES-1:0]        slvHREADYOUT,
  input  logic [SLAVES-1:0]        slvHRESP,
  output logic                     slvHREADY,
  output logic [PRIORITY_BITS-1:0] slvpriority,
  input  logic [SLAVES-1:0]        master_granted,
  output logic                     can_switch,
  output logic                     decode_error
);

  localparam int SLAVES_BITS = (SLAVES > 1) ? $clog2(SLAVES) : 1;
  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;
  localparam logic [2:0] HBURST_SINGLE = 3'b000;
  localparam logic [2:0] HBURST_INCR   = 3'b001;

  typedef enum logic [2:0] {ST_IDLE, ST_PENDING, ST_GRANTED, ST_ERR1, ST_ERR2} state_t;

  state_t                   state_q, state_d;
  logic [HADDR_SIZE-1:0]    haddr_q;
  logic                     hwrite_q;
  logic [2:0]               hsize_q;
  logic [2:0]               hburst_q;
  logic [3:0]               hprot_q;
  logic [1:0]               htrans_q;
  logic                     hmastlock_q;
  logic [PRIORITY_BITS-1:0] priority_q;
  logic [SLAVES_BITS-1:0]   slave_sel_q;
  logic [3:0]               burst_cnt_q, burst_cnt_d;
  logic                     decode_error_q, decode_error_d;

  logic [SLAVES-1:0]        live_hit, reg_hit;
  logic [SLAVES_BITS-1:0]   live_idx, reg_idx, sel_enc;
  logic                     live_any, live_req, live_granted, reg_granted, mux_sel;

  // Address decode for both the live and the held address phase.
  generate
    for (genvar gi = 0; gi < SLAVES; gi++) begin : g_decode
      assign live_hit[gi] = (mst_HADDR & slvHADDRmask[gi]) == (slvHADDRbase[gi] & slvHADDRmask[gi]);
      assign reg_hit[gi]  = (haddr_q & slvHADDRmask[gi]) == (slvHADDRbase[gi] & slvHADDRmask[gi]);
    end
  endgenerate

  // Lowest index wins when several windows overlap.
  always_comb begin
    live_idx = '0;
    reg_idx  = '0;
    for (int s = SLAVES - 1; s >= 0; s--) begin
      if (live_hit[s]) live_idx = SLAVES_BITS'(s);
      if (reg_hit[s])  reg_idx  = SLAVES_BITS'(s);
    end
  end

  assign live_any     = |live_hit;
  assign live_req     = mst_HSEL & mst_HTRANS[1];
  assign live_granted = live_any & master_granted[live_idx];
  assign reg_granted  = master_granted[reg_idx];
  assign mux_sel      = (state_q != ST_PENDING);
  assign sel_enc      = mux_sel ? live_idx : reg_idx;

  function automatic logic [3:0] burst_len_m1(input logic [2:0] hburst);
    case (hburst[2:1])
      2'b01:   return 4'd3;
      2'b10:   return 4'd7;
      2'b11:   return 4'd15;
      default: return 4'd0;
    endcase
  endfunction

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE, ST_GRANTED, ST_ERR2: begin
        if (mst_HREADY) begin
          if (live_req) begin
            if (!live_any)         state_d = ST_ERR1;
            else if (live_granted) state_d = ST_GRANTED;
            else                   state_d = ST_PENDING;
          end else begin
            state_d = ST_IDLE;
          end
        end else if (state_q == ST_ERR2) begin
          state_d = ST_IDLE;
        end
      end
      ST_PENDING: if (reg_granted) state_d = ST_GRANTED;
      ST_ERR1:    state_d = ST_ERR2;
      default:    state_d = ST_IDLE;
    endcase
    decode_error_d = (state_d == ST_ERR1);
  end

  // Slave-side address phase: live while not pending, held copy while waiting for a grant.
  always_comb begin
    slvHWDATA       = mst_HWDATA;
    slvHTRANS4sw    = mst_HTRANS;
    slvHMASTLOCK4sw = mst_HMASTLOCK;
    if (mux_sel) begin
      slvHSEL      = (live_req && live_any) ? (SLAVES'(1) << live_idx) : '0;
      slvHADDR     = mst_HADDR;
      slvHWRITE    = mst_HWRITE;
      slvHSIZE     = mst_HSIZE;
      slvHBURST    = mst_HBURST;
      slvHPROT     = mst_HPROT;
      slvHTRANS    = mst_HTRANS;
      slvHMASTLOCK = mst_HMASTLOCK;
      slvHREADY    = mst_HREADY;
      slvpriority  = mst_priority;
    end else begin
      slvHSEL      = SLAVES'(1) << reg_idx;
      slvHADDR     = haddr_q;
      slvHWRITE    = hwrite_q;
      slvHSIZE     = hsize_q;
      slvHBURST    = hburst_q;
      slvHPROT     = hprot_q;
      // A held SEQ of an undefined-length burst restarts the burst at the new slave port.
      slvHTRANS    = (htrans_q == HTRANS_SEQ && hburst_q == HBURST_INCR) ? HTRANS_NONSEQ : htrans_q;
      slvHMASTLOCK = hmastlock_q;
      slvHREADY    = 1'b1;
      slvpriority  = priority_q;
    end
  end

  always_comb begin
    mst_HRDATA = slvHRDATA[slave_sel_q];
    case (state_q)
      ST_GRANTED: begin
        mst_HREADYOUT = slvHREADYOUT[slave_sel_q];
        mst_HRESP     = slvHRESP[slave_sel_q];
      end
      ST_PENDING: begin mst_HREADYOUT = 1'b0; mst_HRESP = 1'b0; end
      ST_ERR1:    begin mst_HREADYOUT = 1'b0; mst_HRESP = 1'b1; end
      ST_ERR2:    begin mst_HREADYOUT = 1'b1; mst_HRESP = 1'b1; end
      default:    begin mst_HREADYOUT = 1'b1; mst_HRESP = 1'b0; end
    endcase
  end

  always_comb begin
    can_switch = 1'b1;
    case (state_q)
      ST_IDLE, ST_ERR2: can_switch = !(live_req && live_granted);
      ST_PENDING:       can_switch = !reg_granted;
      ST_GRANTED: begin
        can_switch = !mst_HSEL ||
                     (mst_HREADY && !mst_HMASTLOCK &&
                      ((mst_HTRANS == HTRANS_IDLE) ||
                       (mst_HTRANS == HTRANS_NONSEQ && mst_HBURST == HBURST_SINGLE) ||
                       (mst_HTRANS == HTRANS_SEQ && mst_HBURST[2:1] != 2'b00 && burst_cnt_q == 4'd1)));
      end
      default:          can_switch = 1'b1;
    endcase
  end

  always_comb begin
    burst_cnt_d = burst_cnt_q;
    if (mst_HREADY) begin
      if (!mst_HSEL || mst_HTRANS == HTRANS_IDLE)           burst_cnt_d = 4'd0;
      else if (mst_HTRANS == HTRANS_NONSEQ)                 burst_cnt_d = burst_len_m1(mst_HBURST);
      else if (mst_HTRANS == HTRANS_SEQ && burst_cnt_q != 0) burst_cnt_d = burst_cnt_q - 4'd1;
    end
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state_q        <= ST_IDLE;
      haddr_q        <= '0;
      hwrite_q       <= 1'b0;
      hsize_q        <= 3'd0;
      hburst_q       <= 3'd0;
      hprot_q        <= 4'd0;
      htrans_q       <= HTRANS_IDLE;
      hmastlock_q    <= 1'b0;
      priority_q     <= '0;
      slave_sel_q    <= '0;
      burst_cnt_q    <= 4'd0;
      decode_error_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      decode_error_q <= decode_error_d;
      burst_cnt_q    <= burst_cnt_d;
      if (mst_HREADY) begin
        haddr_q     <= mst_HADDR;
        hwrite_q    <= mst_HWRITE;
        hsize_q     <= mst_HSIZE;
        hburst_q    <= mst_HBURST;
        hprot_q     <= mst_HPROT;
        htrans_q    <= mst_HSEL ? mst_HTRANS : HTRANS_IDLE;
        hmastlock_q <= mst_HMASTLOCK;
        priority_q  <= mst_priority;
      end
      // Only real slave selections move the data-phase mux, so unmapped accesses leave it alone.
      if (slvHREADY && (|slvHSEL)) slave_sel_q <= sel_enc;
    end
  end

  assign decode_error = decode_error_q;

endmodule

// File: tb/tb_ahb_switch_master_port_derr.sv
// Directed bench for ahb_switch_master_port_derr with four slaves at 256 MB windows.
module tb_ahb_switch_master_port_derr;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  mst_priority;
  logic        mst_HSEL;
  logic [31:0] mst_HADDR;
  logic [31:0] mst_HWDATA;
  logic        mst_HWRITE;
  logic [2:0]  mst_HSIZE;
  logic [2:0]  mst_HBURST;
  logic [3:0]  mst_HPROT;
  logic [1:0]  mst_HTRANS;
  logic        mst_HMASTLOCK;
  logic        mst_HREADY;
  logic [31:0] mst_HRDATA;
  logic        mst_HREADYOUT;
  logic        mst_HRESP;
  logic [31:0] mask [4];
  logic [31:0] base [4];
  logic [31:0] rdata [4];
  logic [3:0]  slvHSEL;
  logic [31:0] slvHADDR;
  logic [31:0] slvHWDATA;
  logic        slvHWRITE;
  logic [2:0]  slvHSIZE;
  logic [2:0]  slvHBURST;
  logic [3:0]  slvHPROT;
  logic [1:0]  slvHTRANS;
  logic        slvHMASTLOCK;
  logic [1:0]  slvHTRANS4sw;
  logic        slvHMASTLOCK4sw;
  logic [3:0]  slvHREADYOUT;
  logic [3:0]  slvHRESP;
  logic        slvHREADY;
  logic [2:0]  slvpriority;
  logic [3:0]  master_granted;
  logic        can_switch;
  logic        decode_error;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Single-layer bus: the master's HREADY is this port's own HREADYOUT.
  assign mst_HREADY = mst_HREADYOUT;

  ahb_switch_master_port_derr #(
    .HADDR_SIZE(32), .HDATA_SIZE(32), .SLAVES(4), .PRIORITY_BITS(3)
  ) dut (
    .HCLK(clk), .HRESET(rst), .mst_priority(mst_priority),
    .mst_HSEL(mst_HSEL), .mst_HADDR(mst_HADDR), .mst_HWDATA(mst_HWDATA),
    .mst_HWRITE(mst_HWRITE), .mst_HSIZE(mst_HSIZE), .mst_HBURST(mst_HBURST),
    .mst_HPROT(mst_HPROT), .mst_HTRANS(mst_HTRANS), .mst_HMASTLOCK(mst_HMASTLOCK),
    .mst_HREADY(mst_HREADY), .mst_HRDATA(mst_HRDATA), .mst_HREADYOUT(mst_HREADYOUT),
    .mst_HRESP(mst_HRESP), .slvHADDRmask(mask), .slvHADDRbase(base),
    .slvHSEL(slvHSEL), .slvHADDR(slvHADDR), .slvHWDATA(slvHWDATA),
    .slvHWRITE(slvHWRITE), .slvHSIZE(slvHSIZE), .slvHBURST(slvHBURST),
    .slvHPROT(slvHPROT), .slvHTRANS(slvHTRANS), .slvHMASTLOCK(slvHMASTLOCK),
    .slvHTRANS4sw(slvHTRANS4sw), .slvHMASTLOCK4sw(slvHMASTLOCK4sw),
    .slvHRDATA(rdata), .slvHREADYOUT(slvHREADYOUT), .slvHRESP(slvHRESP),
    .slvHREADY(slvHREADY), .slvpriority(slvpriority), .master_granted(master_granted),
    .can_switch(can_switch), .decode_error(decode_error)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic drive(input logic [1:0] trans, input logic [31:0] addr, input logic [2:0] burst,
                       input logic wr, input logic lock);
    mst_HSEL      = 1'b1;
    mst_HTRANS    = trans;
    mst_HADDR     = addr;
    mst_HBURST    = burst;
    mst_HWRITE    = wr;
    mst_HMASTLOCK = lock;
  endtask

  initial begin
    rst = 1'b1;
    mst_priority = 3'd0; mst_HSEL = 1'b0; mst_HADDR = '0; mst_HWDATA = 32'h1234_5678;
    mst_HWRITE = 1'b0; mst_HSIZE = 3'd2; mst_HBURST = 3'd0; mst_HPROT = 4'd3;
    mst_HTRANS = 2'b00; mst_HMASTLOCK = 1'b0; master_granted = 4'b0000;
    slvHREADYOUT = 4'b1111; slvHRESP = 4'b0000;
    for (int s = 0; s < 4; s++) begin
      mask[s]  = 32'hF000_0000;
      base[s]  = 32'(s) << 28;
      rdata[s] = 32'hDA7A_0000 + 32'(s);
    end

    // Reset state
    repeat (2) @(posedge clk);
    sample();
    chk("rst_hreadyout", mst_HREADYOUT, 1);
    chk("rst_hresp", mst_HRESP, 0);
    chk("rst_decode_error", decode_error, 0);
    chk("rst_can_switch", can_switch, 1);
    chk("rst_slvhsel", slvHSEL, 0);
    chk("rst_hrdata_sel0", mst_HRDATA, 32'hDA7A_0000);
    rst = 1'b0;

    // Granted single read to slave 2
    next_cycle();
    master_granted = 4'b0100;
    drive(2'b10, 32'h2000_0010, 3'b000, 1'b0, 1'b0);
    sample();
    chk("gnt_slvhsel", slvHSEL, 4'b0100);
    chk("gnt_slvhaddr", slvHADDR, 32'h2000_0010);
    chk("gnt_can_switch", can_switch, 0);
    next_cycle();
    drive(2'b00, 32'h0, 3'b000, 1'b0, 1'b0);
    sample();
    chk("gnt_hrdata", mst_HRDATA, 32'hDA7A_0002);
    chk("gnt_hresp", mst_HRESP, 0);
    chk("gnt_hreadyout", mst_HREADYOUT, 1);
    chk("gnt_idle_can_switch", can_switch, 1);

    // Pending write to slave 1; grant arrives in the third held cycle
    next_cycle();
    master_granted = 4'b0000;
    mst_priority = 3'd5;
    drive(2'b10, 32'h1000_0000, 3'b000, 1'b1, 1'b0);
    sample();
    chk("pnd_req_slvhsel", slvHSEL, 4'b0010);
    chk("pnd_req_can_switch", can_switch, 1);
    next_cycle();
    mst_HADDR = 32'h3000_0040;
    mst_priority = 3'd1;
    for (int c = 0; c < 3; c++) begin
      if (c > 0) next_cycle();
      if (c == 2) master_granted = 4'b0010;
      sample();
      chk("pnd_hreadyout", mst_HREADYOUT, 0);
      chk("pnd_slvhsel", slvHSEL, 4'b0010);
      chk("pnd_slvhaddr", slvHADDR, 32'h1000_0000);
      chk("pnd_can_switch", can_switch, (c == 2) ? 0 : 1);
    end
    chk("pnd_slvhready", slvHREADY, 1);
    chk("pnd_slvpriority", slvpriority, 3'd5);
    chk("pnd_slvhwrite", slvHWRITE, 1);
    next_cycle();
    drive(2'b00, 32'h0, 3'b000, 1'b0, 1'b0);
    mst_priority = 3'd0;
    sample();
    chk("pnd_granted_hreadyout", mst_HREADYOUT, 1);
    chk("pnd_granted_hrdata", mst_HRDATA, 32'hDA7A_0001);

    // Unmapped access: slave 0 moved away, 0x0000_0004 matches nothing
    next_cycle();
    base[0] = 32'h5000_0000;
    master_granted = 4'b0000;
    drive(2'b10, 32'h0000_0004, 3'b000, 1'b0, 1'b0);
    sample();
    chk("err_req_slvhsel", slvHSEL, 0);
    chk("err_req_decode_error", decode_error, 0);
    next_cycle();
    drive(2'b00, 32'h0, 3'b000, 1'b0, 1'b0);
    sample();
    chk("err1_decode_error", decode_error, 1);
    chk("err1_hreadyout", mst_HREADYOUT, 0);
    chk("err1_hresp", mst_HRESP, 1);
    chk("err1_slvhsel", slvHSEL, 0);
    next_cycle();
    sample();
    chk("err2_decode_error", decode_error, 0);
    chk("err2_hreadyout", mst_HREADYOUT, 1);
    chk("err2_hresp", mst_HRESP, 1);
    chk("err2_slvhsel", slvHSEL, 0);
    next_cycle();
    sample();
    chk("err_done_hresp", mst_HRESP, 0);
    chk("err_done_hreadyout", mst_HREADYOUT, 1);
    base[0] = 32'h0000_0000;

    // INCR8 bursts to slave 1, unlocked then locked
    for (int lk = 0; lk < 2; lk++) begin
      next_cycle();
      master_granted = 4'b0010;
      drive(2'b10, 32'h1000_0000, 3'b101, 1'b0, lk[0]);
      sample();
      chk("incr8_beat1_can_switch", can_switch, 0);
      for (int b = 2; b <= 8; b++) begin
        next_cycle();
        drive(2'b11, 32'h1000_0000 + 32'((b - 1) * 4), 3'b101, 1'b0, lk[0]);
        sample();
        chk("incr8_seq_can_switch", can_switch, (lk == 0 && b == 8) ? 1 : 0);
      end
      next_cycle();
      drive(2'b00, 32'h0, 3'b000, 1'b0, 1'b0);
      sample();
      chk("incr8_end_can_switch", can_switch, 1);
    end

    // Overlapping windows: slaves 0 and 1 both at base 0
    next_cycle();
    base[1] = 32'h0000_0000;
    master_granted = 4'b0011;
    drive(2'b10, 32'h0000_0100, 3'b000, 1'b0, 1'b0);
    sample();
    chk("overlap_slvhsel", slvHSEL, 4'b0001);
    next_cycle();
    drive(2'b00, 32'h0, 3'b000, 1'b0, 1'b0);
    sample();
    chk("overlap_hrdata", mst_HRDATA, 32'hDA7A_0000);
    base[1] = 32'h1000_0000;

    // Asynchronous reset while an INCR4 waits for its grant
    next_cycle();
    master_granted = 4'b0000;
    drive(2'b10, 32'h2000_0000, 3'b011, 1'b0, 1'b0);
    next_cycle();
    sample();
    chk("arst_pending_hreadyout", mst_HREADYOUT, 0);
    chk("arst_pending_hrdata", mst_HRDATA, 32'hDA7A_0002);
    #2;
    rst = 1'b1;
    mst_HSEL = 1'b0;
    mst_HTRANS = 2'b00;
    #1;
    chk("arst_hreadyout", mst_HREADYOUT, 1);
    chk("arst_hresp", mst_HRESP, 0);
    chk("arst_decode_error", decode_error, 0);
    chk("arst_can_switch", can_switch, 1);
    chk("arst_slvhsel", slvHSEL, 0);
    chk("arst_hrdata", mst_HRDATA, 32'hDA7A_0000);
    @(posedge clk);
    sample();
    rst = 1'b0;
    next_cycle();
    master_granted = 4'b1000;
    drive(2'b10, 32'h3000_0008, 3'b000, 1'b0, 1'b0);
    sample();
    chk("post_rst_slvhsel", slvHSEL, 4'b1000);
    chk("post_rst_hreadyout", mst_HREADYOUT, 1);
    next_cycle();
    drive(2'b00, 32'h0, 3'b000, 1'b0, 1'b0);
    sample();
    chk("post_rst_hrdata", mst_HRDATA, 32'hDA7A_0003);
    chk("post_rst_hresp", mst_HRESP, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
